// File: rtl/crossbar_rsp_router.sv
// crossbar_rsp_router
//
// Read-response return path from the SRAM banks to the requesters (PEs plus
// config port). Each cycle the bank read grants are transposed into a per-PE
// bank bitmap. That map is delayed by the bank read latency and then used to
// steer the live bank read data to each requester with a valid strobe.
//
// Optional feature macro: CROSSBAR_RSP_REG_EN
//   defined   : o_valid/o_rdata/o_bank/o_conflict are registered (+1 cycle)
//   undefined : outputs are combinational from the tail map and i_rdata
//
// Ports
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_grant         [b*N_PE +: N_PE] = PEs granted a read on bank b
//   i_rdata         [b*DATA_W +: DATA_W] = bank b read data (RD_LAT after grant)
//   o_valid         response valid per PE
//   o_rdata         response data per PE
//   o_bank          source bank index per PE
//   o_conflict      pulse: some PE received more than one bank response
//   o_conflict_cnt  saturating count of conflict cycles
module crossbar_rsp_router #(
  parameter int N_BANK = 4,
  parameter int N_PE   = 4,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_BANK*N_PE-1:0]     i_grant,
  input  logic [N_BANK*DATA_W-1:0]   i_rdata,
  output logic [N_PE-1:0]            o_valid,
  output logic [N_PE*DATA_W-1:0]     o_rdata,
  output logic [N_PE*BANK_W-1:0]     o_bank,
  output logic                       o_conflict,
  output logic [15:0]                o_conflict_cnt
);

  localparam int MAP_W = N_PE * N_BANK;

  // Per-PE bank bitmap, PE-major: grant_map[p*N_BANK + b].
  logic [MAP_W-1:0] grant_map;

  always_comb begin
    grant_map = '0;
    for (int unsigned p = 0; p < N_PE; p++) begin
      for (int unsigned b = 0; b < N_BANK; b++) begin
        grant_map[p*N_BANK + b] = i_grant[b*N_PE + p];
      end
    end
  end

  // Latency pipeline; stage 0 captures the transpose, stage RD_LAT-1 is the tail.
  logic [MAP_W-1:0] pipe_q [RD_LAT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= grant_map;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  logic [MAP_W-1:0]        tail_map;
  logic [N_PE-1:0]         tail_valid;
  logic [N_PE*DATA_W-1:0]  tail_rdata;
  logic [N_PE*BANK_W-1:0]  tail_bank;
  logic                    tail_conflict;

  assign tail_map = pipe_q[RD_LAT-1];

  // Lowest set bank wins; more than one set bit in a PE's map is a conflict.
  always_comb begin : tail_decode
    logic [N_BANK-1:0] pe_map;
    logic              found;
    pe_map        = '0;
    found         = 1'b0;
    tail_valid    = '0;
    tail_rdata    = '0;
    tail_bank     = '0;
    tail_conflict = 1'b0;
    for (int unsigned p = 0; p < N_PE; p++) begin
      pe_map        = tail_map[p*N_BANK +: N_BANK];
      found         = 1'b0;
      tail_valid[p] = |pe_map;
      // x & (x-1) is non-zero exactly when x has two or more bits set.
      if ((pe_map & (pe_map - N_BANK'(1))) != '0) begin
        tail_conflict = 1'b1;
      end
      for (int unsigned b = 0; b < N_BANK; b++) begin
        if (pe_map[b] && !found) begin
          found                          = 1'b1;
          tail_bank[p*BANK_W +: BANK_W]  = BANK_W'(b);
          tail_rdata[p*DATA_W +: DATA_W] = i_rdata[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Counts from the tail-cycle conflict, so in the registered build it
  // advances on the same edge that registers o_conflict.
  logic [15:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (tail_conflict && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign o_conflict_cnt = cnt_q;

`ifdef CROSSBAR_RSP_REG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= '0;
      o_rdata    <= '0;
      o_bank     <= '0;
      o_conflict <= 1'b0;
    end else begin
      o_valid    <= tail_valid;
      o_rdata    <= tail_rdata;
      o_bank     <= tail_bank;
      o_conflict <= tail_conflict;
    end
  end
`else
  assign o_valid    = tail_valid;
  assign o_rdata    = tail_rdata;
  assign o_bank     = tail_bank;
  assign o_conflict = tail_conflict;
`endif

endmodule

// File: tb/tb_crossbar_rsp_router.sv
module tb_crossbar_rsp_router;

`ifdef CROSSBAR_RSP_REG_EN
  localparam int REG = 1;
`else
  localparam int REG = 0;
`endif
  localparam int LAT_A = 2 + REG;
  localparam int LAT_B = 4 + REG;
  localparam int NCYC  = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic [15:0]  grant_a = '0;
  logic [127:0] rdata_a = '0;
  logic [3:0]   valid_a;
  logic [127:0] out_rdata_a;
  logic [7:0]   bank_a;
  logic         conf_a;
  logic [15:0]  cnt_a;

  // Instance B: N_BANK=8, N_PE=3, DATA_W=64, RD_LAT=4
  logic [23:0]  grant_b = '0;
  logic [511:0] rdata_b = '0;
  logic [2:0]   valid_b;
  logic [191:0] out_rdata_b;
  logic [8:0]   bank_b;
  logic         conf_b;
  logic [15:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  crossbar_rsp_router dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_grant(grant_a), .i_rdata(rdata_a),
    .o_valid(valid_a), .o_rdata(out_rdata_a), .o_bank(bank_a),
    .o_conflict(conf_a), .o_conflict_cnt(cnt_a)
  );

  crossbar_rsp_router #(.N_BANK(8), .N_PE(3), .DATA_W(64), .RD_LAT(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_grant(grant_b), .i_rdata(rdata_b),
    .o_valid(valid_b), .o_rdata(out_rdata_b), .o_bank(bank_b),
    .o_conflict(conf_b), .o_conflict_cnt(cnt_b)
  );

  // One cycle of stimulus on A; returns at the following negedge for sampling.
  task automatic drive_a(input logic [15:0] g, input logic [127:0] d);
    @(posedge clk); #1;
    grant_a = g;
    rdata_a = d;
    @(negedge clk);
  endtask

  task automatic drive_b(input logic [23:0] g, input logic [511:0] d);
    @(posedge clk); #1;
    grant_b = g;
    rdata_b = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    grant_a = '0; rdata_a = '0; grant_b = '0; rdata_b = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    grant_a = 16'hFFFF;
    grant_b = '1;
    rdata_a = '1;
    rdata_b = '1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_a !== 4'h0) begin n_errors++; $display("FAIL reset_valid_a: got %h expected 0", valid_a); end
    n_checks++; if (out_rdata_a !== 128'h0) begin n_errors++; $display("FAIL reset_rdata_a: got %h expected 0", out_rdata_a); end
    n_checks++; if (bank_a !== 8'h0) begin n_errors++; $display("FAIL reset_bank_a: got %h expected 0", bank_a); end
    n_checks++; if (conf_a !== 1'b0) begin n_errors++; $display("FAIL reset_conflict_a: got %b expected 0", conf_a); end
    n_checks++; if (cnt_a !== 16'h0) begin n_errors++; $display("FAIL reset_cnt_a: got %h expected 0", cnt_a); end
    n_checks++; if (valid_b !== 3'h0) begin n_errors++; $display("FAIL reset_valid_b: got %h expected 0", valid_b); end
    n_checks++; if (out_rdata_b !== 192'h0) begin n_errors++; $display("FAIL reset_rdata_b: got %h expected 0", out_rdata_b); end
    n_checks++; if (bank_b !== 9'h0) begin n_errors++; $display("FAIL reset_bank_b: got %h expected 0", bank_b); end
    n_checks++; if (conf_b !== 1'b0 || cnt_b !== 16'h0) begin n_errors++; $display("FAIL reset_conf_b: got %b/%h expected 0/0", conf_b, cnt_b); end
    grant_a = '0; grant_b = '0; rdata_a = '0; rdata_b = '0;
    rst_n = 1'b1;
    repeat (3) drive_a('0, '0);
  endtask

  task automatic test_single_read();
    logic [127:0] d, exp_rd;
    logic [7:0]   exp_bank;
    exp_rd = '0;  exp_rd[63:32] = 32'hDEADBEEF;
    exp_bank = '0; exp_bank[3:2] = 2'd2;
    drive_a(16'h0200, '0);  // bank 2 -> PE1
    for (int c = 1; c <= LAT_A + 1; c++) begin
      d = '0;
      if (c == 2) d[95:64] = 32'hDEADBEEF;
      drive_a('0, d);
      if (c == LAT_A) begin
        n_checks++; if (valid_a !== 4'b0010) begin n_errors++; $display("FAIL single_valid: got %b expected 0010", valid_a); end
        n_checks++; if (out_rdata_a !== exp_rd) begin n_errors++; $display("FAIL single_rdata: got %h expected %h", out_rdata_a, exp_rd); end
        n_checks++; if (bank_a !== exp_bank) begin n_errors++; $display("FAIL single_bank: got %h expected %h", bank_a, exp_bank); end
      end else begin
        n_checks++; if (valid_a !== 4'b0000) begin n_errors++; $display("FAIL single_idle c=%0d: got %b expected 0000", c, valid_a); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] dh [8];
    logic [15:0]  g;
    int k;
    for (int c = 0; c <= LAT_A + 4; c++) begin
      g = (c < 4) ? (16'h0001 << (c*4)) : 16'h0;
      for (int b = 0; b < 4; b++) dh[c][b*32 +: 32] = 32'hB000_0000 | 32'(c << 8) | 32'(b);
      drive_a(g, dh[c]);
      if (c >= LAT_A && c < LAT_A + 4) begin
        k = c - LAT_A;
        n_checks++; if (valid_a !== 4'b0001) begin n_errors++; $display("FAIL b2b_valid c=%0d: got %b expected 0001", c, valid_a); end
        n_checks++; if (out_rdata_a[31:0] !== dh[c-REG][k*32 +: 32]) begin n_errors++; $display("FAIL b2b_rdata c=%0d: got %h expected %h", c, out_rdata_a[31:0], dh[c-REG][k*32 +: 32]); end
        n_checks++; if (bank_a[1:0] !== 2'(k)) begin n_errors++; $display("FAIL b2b_bank c=%0d: got %0d expected %0d", c, bank_a[1:0], k); end
      end else begin
        n_checks++; if (valid_a !== 4'b0000) begin n_errors++; $display("FAIL b2b_idle c=%0d: got %b expected 0000", c, valid_a); end
      end
    end
  endtask

  task automatic test_broadcast();
    logic [127:0] d;
    for (int c = 0; c <= LAT_A + 1; c++) begin
      d = '0;
      if (c == 2) d[127:96] = 32'h12345678;
      drive_a((c == 0) ? 16'hF000 : 16'h0, d);
      if (c == LAT_A) begin
        n_checks++; if (valid_a !== 4'b1111) begin n_errors++; $display("FAIL bcast_valid: got %b expected 1111", valid_a); end
        n_checks++; if (out_rdata_a !== {4{32'h12345678}}) begin n_errors++; $display("FAIL bcast_rdata: got %h expected %h", out_rdata_a, {4{32'h12345678}}); end
        n_checks++; if (bank_a !== {4{2'd3}}) begin n_errors++; $display("FAIL bcast_bank: got %h expected %h", bank_a, {4{2'd3}}); end
        n_checks++; if (conf_a !== 1'b0) begin n_errors++; $display("FAIL bcast_conflict: got %b expected 0", conf_a); end
      end else begin
        n_checks++; if (valid_a !== 4'b0000) begin n_errors++; $display("FAIL bcast_idle c=%0d: got %b expected 0000", c, valid_a); end
      end
    end
  endtask

  task automatic test_conflict();
    logic [127:0] d;
    do_reset();
    for (int c = 0; c <= LAT_A + 1; c++) begin
      d = '0;
      if (c == 2) begin d[63:32] = 32'hA; d[127:96] = 32'hB; end
      drive_a((c == 0) ? 16'h4040 : 16'h0, d);  // banks 1 and 3 -> PE2
      if (c == LAT_A) begin
        n_checks++; if (valid_a !== 4'b0100) begin n_errors++; $display("FAIL conf_valid: got %b expected 0100", valid_a); end
        n_checks++; if (out_rdata_a[95:64] !== 32'hA) begin n_errors++; $display("FAIL conf_rdata: got %h expected 0000000a", out_rdata_a[95:64]); end
        n_checks++; if (bank_a[5:4] !== 2'd1) begin n_errors++; $display("FAIL conf_bank: got %0d expected 1", bank_a[5:4]); end
        n_checks++; if (conf_a !== 1'b1) begin n_errors++; $display("FAIL conf_pulse: got %b expected 1", conf_a); end
        n_checks++; if (cnt_a !== 16'(REG)) begin n_errors++; $display("FAIL conf_cnt_same: got %0d expected %0d", cnt_a, REG); end
      end else if (c == LAT_A + 1) begin
        n_checks++; if (conf_a !== 1'b0) begin n_errors++; $display("FAIL conf_pulse_end: got %b expected 0", conf_a); end
        n_checks++; if (cnt_a !== 16'd1) begin n_errors++; $display("FAIL conf_cnt_one: got %0d expected 1", cnt_a); end
      end else begin
        n_checks++; if (conf_a !== 1'b0) begin n_errors++; $display("FAIL conf_early c=%0d: got %b expected 0", c, conf_a); end
      end
    end
    for (int i = 0; i < 70000; i++) drive_a(16'h4040, {4{$urandom}});
    n_checks++; if (conf_a !== 1'b1) begin n_errors++; $display("FAIL sat_pulse: got %b expected 1", conf_a); end
    n_checks++; if (cnt_a !== 16'hFFFF) begin n_errors++; $display("FAIL sat_cnt: got %h expected ffff", cnt_a); end
    repeat (LAT_A + 2) drive_a('0, '0);
    n_checks++; if (conf_a !== 1'b0) begin n_errors++; $display("FAIL sat_idle: got %b expected 0", conf_a); end
    n_checks++; if (cnt_a !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold: got %h expected ffff", cnt_a); end
  endtask

  task automatic test_reset_midflight();
    logic [127:0] d;
    d = '0; d[63:32] = 32'hCAFE_F00D;
    drive_a(16'h0020, '0);  // bank 1 -> PE1 at T
    @(posedge clk); #1;
    grant_a = '0;
    rdata_a = d;
    rst_n   = 1'b0;
    #1;
    n_checks++; if (valid_a !== 4'h0 || conf_a !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b/%b expected 0/0", valid_a, conf_a); end
    n_checks++; if (out_rdata_a !== 128'h0 || bank_a !== 8'h0) begin n_errors++; $display("FAIL midrst_data: got %h/%h expected 0/0", out_rdata_a, bank_a); end
    n_checks++; if (cnt_a !== 16'h0) begin n_errors++; $display("FAIL midrst_cnt: got %h expected 0", cnt_a); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 2; c <= LAT_A + 2; c++) begin
      drive_a('0, d);
      n_checks++; if (valid_a !== 4'h0) begin n_errors++; $display("FAIL midrst_after c=%0d: got %b expected 0000", c, valid_a); end
    end
  endtask

  task automatic test_param_sweep();
    logic [23:0]  gh [NCYC];
    logic [511:0] dh [NCYC];
    logic [23:0]  g;
    logic [511:0] dd;
    logic [2:0]   exp_v;
    logic [191:0] exp_d;
    logic [8:0]   exp_b;
    logic         exp_c;
    int           exp_cnt, hits;
    do_reset();
    exp_cnt = 0;
    for (int c = 0; c < NCYC; c++) begin
      g = '0;
      if (c % 10 != 9)
        for (int i = 0; i < 24; i++) g[i] = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < 8; b++) dh[c][b*64 +: 64] = {$urandom, $urandom};
      gh[c] = g;
      drive_b(g, dh[c]);
      exp_v = '0; exp_d = '0; exp_b = '0; exp_c = 1'b0;
      if (c >= LAT_B) begin
        g  = gh[c - LAT_B];
        dd = dh[c - REG];
        for (int p = 0; p < 3; p++) begin
          hits = 0;
          for (int b = 0; b < 8; b++) begin
            if (g[b*3 + p]) begin
              hits++;
              if (hits == 1) begin
                exp_v[p] = 1'b1;
                exp_d[p*64 +: 64] = dd[b*64 +: 64];
                exp_b[p*3 +: 3] = 3'(b);
              end
            end
          end
          if (hits > 1) exp_c = 1'b1;
        end
      end
      if (REG == 1 && exp_c && exp_cnt < 65535) exp_cnt++;
      n_checks++; if (valid_b !== exp_v) begin n_errors++; $display("FAIL sweep_valid c=%0d: got %b expected %b", c, valid_b, exp_v); end
      n_checks++; if (out_rdata_b !== exp_d) begin n_errors++; $display("FAIL sweep_rdata c=%0d: got %h expected %h", c, out_rdata_b, exp_d); end
      n_checks++; if (bank_b !== exp_b) begin n_errors++; $display("FAIL sweep_bank c=%0d: got %h expected %h", c, bank_b, exp_b); end
      n_checks++; if (conf_b !== exp_c) begin n_errors++; $display("FAIL sweep_conflict c=%0d: got %b expected %b", c, conf_b, exp_c); end
      n_checks++; if (cnt_b !== 16'(exp_cnt)) begin n_errors++; $display("FAIL sweep_cnt c=%0d: got %0d expected %0d", c, cnt_b, exp_cnt); end
      if (REG == 0 && exp_c && exp_cnt < 65535) exp_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_broadcast();
    test_conflict();
    test_reset_midflight();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
